// File: rtl/div_pkg.sv
// Shared definitions for the divider issue tracker: op encodings, pipeline
// depth and the per-stage side-pipeline tag.
package div_pkg;

  localparam int unsigned DIV_DEPTH = 8;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  // RISC-V quotient for any division by zero.
  localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

  // One side-pipeline entry, travelling in lock-step with a divider stage.
  typedef struct packed {
    logic        vld;
    logic [4:0]  rd;
    logic [1:0]  op;
    logic        dz;
    logic [31:0] dividend;
  } div_tag_t;

endpackage

// File: rtl/div_fixup.sv
// Result select at the divider output, with the RISC-V zero-divisor override.
module div_fixup
  import div_pkg::*;
(
  input  logic        is_rem,
  input  logic        dz,
  input  logic [31:0] dividend,
  input  logic [31:0] quotient,
  input  logic [31:0] remainder,
  output logic [31:0] data
);

  // The divider's raw result for x/0 is wrong for negative signed dividends,
  // so zero divisors bypass it entirely.
  always_comb begin
    data = quotient;
    if (is_rem) begin
      data = dz ? dividend : remainder;
    end else begin
      data = dz ? DIV_ZERO_QUOT : quotient;
    end
  end

endmodule

// File: rtl/div_issue_tracker.sv
// Control wrapper around the pipelined divider: drives operands, tracks each
// in-flight op in a side pipeline, and produces writeback plus busy scoreboard.
module div_issue_tracker
  import div_pkg::*;
#(
  parameter int unsigned DEPTH = DIV_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        i_flush,
  input  logic        i_valid,
  input  logic [1:0]  i_op,
  input  logic [4:0]  i_rd,
  input  logic [31:0] i_rs1,
  input  logic [31:0] i_rs2,
  output logic        o_div_is_signed,
  output logic [31:0] o_div_dividend,
  output logic [31:0] o_div_divisor,
  input  logic [31:0] i_div_quotient,
  input  logic [31:0] i_div_remainder,
  output logic        o_wb_valid,
  output logic [4:0]  o_wb_rd,
  output logic [31:0] o_wb_data,
  output logic [31:0] o_busy,
  output logic [3:0]  o_inflight
);

  div_tag_t    tag_q [DEPTH];
  div_tag_t    tag_d [DEPTH];
  div_tag_t    issue_tag;
  logic [31:0] fix_data;

  // Candidate entry-0 tag; a flush in the same cycle refuses the issue.
  always_comb begin
    issue_tag          = '0;
    issue_tag.vld      = i_valid & ~i_flush;
    issue_tag.rd       = i_rd;
    issue_tag.op       = i_op;
    issue_tag.dz       = (i_rs2 == 32'd0);
    issue_tag.dividend = i_rs1;
  end

  // Divider operands; an idle issue port feeds the divider a zero bubble.
  always_comb begin
    o_div_is_signed = 1'b0;
    o_div_dividend  = 32'd0;
    o_div_divisor   = 32'd0;
    if (i_valid) begin
      o_div_is_signed = ~i_op[0];
      o_div_dividend  = i_rs1;
      o_div_divisor   = i_rs2;
    end
  end

  // Shift on non-stalled edges; flush clears every valid bit even when stalled.
  always_comb begin
    tag_d = tag_q;
    if (!stall) begin
      tag_d[0] = issue_tag;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        tag_d[k] = tag_q[k-1];
      end
    end
    if (i_flush) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        tag_d[k].vld = 1'b0;
      end
    end
  end

  // Side-pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      tag_q <= tag_d;
    end
  end

  div_fixup u_fixup (
    .is_rem    (tag_q[DEPTH-1].op[1]),
    .dz        (tag_q[DEPTH-1].dz),
    .dividend  (tag_q[DEPTH-1].dividend),
    .quotient  (i_div_quotient),
    .remainder (i_div_remainder),
    .data      (fix_data)
  );

  // Writeback beat from the last entry; data is zeroed when idle because the
  // divider datapath itself is never reset.
  always_comb begin
    o_wb_valid = tag_q[DEPTH-1].vld & (tag_q[DEPTH-1].rd != 5'd0) & ~stall;
    o_wb_rd    = tag_q[DEPTH-1].rd;
    o_wb_data  = tag_q[DEPTH-1].vld ? fix_data : 32'd0;
  end

  // Busy scoreboard and in-flight popcount over all entries.
  always_comb begin
    o_busy     = '0;
    o_inflight = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (tag_q[k].vld) begin
        o_busy[tag_q[k].rd] = 1'b1;
      end
      o_inflight = o_inflight + {3'b000, tag_q[k].vld};
    end
    o_busy[0] = 1'b0;
  end

endmodule

// File: tb/tb_div_issue_tracker.sv
// Bench for div_issue_tracker with a behavioural 8-stage divider model and a
// scoreboard of expected writeback beats.
module tb_div_issue_tracker;
  import div_pkg::*;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        i_flush;
  logic        i_valid;
  logic [1:0]  i_op;
  logic [4:0]  i_rd;
  logic [31:0] i_rs1;
  logic [31:0] i_rs2;
  logic        o_div_is_signed;
  logic [31:0] o_div_dividend;
  logic [31:0] o_div_divisor;
  logic [31:0] div_q;
  logic [31:0] div_r;
  logic        o_wb_valid;
  logic [4:0]  o_wb_rd;
  logic [31:0] o_wb_data;
  logic [31:0] o_busy;
  logic [3:0]  o_inflight;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  div_issue_tracker dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .i_flush         (i_flush),
    .i_valid         (i_valid),
    .i_op            (i_op),
    .i_rd            (i_rd),
    .i_rs1           (i_rs1),
    .i_rs2           (i_rs2),
    .o_div_is_signed (o_div_is_signed),
    .o_div_dividend  (o_div_dividend),
    .o_div_divisor   (o_div_divisor),
    .i_div_quotient  (div_q),
    .i_div_remainder (div_r),
    .o_wb_valid      (o_wb_valid),
    .o_wb_rd         (o_wb_rd),
    .o_wb_data       (o_wb_data),
    .o_busy          (o_busy),
    .o_inflight      (o_inflight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Raw divider: x/0 deliberately mis-handles negative signed dividends.
  function automatic logic [63:0] raw_div(input logic sgn, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sd;
    logic [31:0] q;
    logic [31:0] r;
    sa = a;
    sd = b;
    if (b == 32'd0) begin
      q = (sgn && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
      r = (sgn && a[31]) ? (32'd0 - a) : a;
    end else if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = a;
        r = 32'd0;
      end else begin
        q = sa / sd;
        r = sa % sd;
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r};
  endfunction

  logic [31:0] dq [8];
  logic [31:0] dr [8];
  logic [63:0] dres;
  assign dres  = raw_div(o_div_is_signed, o_div_dividend, o_div_divisor);
  assign div_q = dq[7];
  assign div_r = dr[7];

  always @(posedge clk) begin
    if (!stall) begin
      dq[0] <= dres[63:32];
      dr[0] <= dres[31:0];
      for (int k = 1; k < 8; k++) begin
        dq[k] <= dq[k-1];
        dr[k] <= dr[k-1];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one op for one cycle; expected beat lands lat cycles later.
  task automatic issue(input logic [1:0] op, input logic [4:0] rd, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat,
                       input bit push);
    exp_t e;
    i_valid = 1'b1;
    i_op    = op;
    i_rd    = rd;
    i_rs1   = a;
    i_rs2   = b;
    if (push && rd != 5'd0) begin
      e.rd   = rd;
      e.data = exp;
      e.cyc  = cyc + lat;
      sb.push_back(e);
    end
    tick();
    i_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && sb.size() != 0; i++) tick();
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  // Writeback monitor, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && stall) chk("wb_during_stall", {63'd0, o_wb_valid}, 64'd0);
    if (!rst && o_wb_valid) begin
      checks++;
      assert (sb.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_beat: observed rd=%0d data=%0h expected none", o_wb_rd,
               o_wb_data);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("wb_rd", {59'd0, o_wb_rd}, {59'd0, e.rd});
        chk("wb_data", {32'd0, o_wb_data}, {32'd0, e.data});
        chk("wb_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; i_flush = 1'b0; i_valid = 1'b0;
    i_op = '0; i_rd = '0; i_rs1 = '0; i_rs2 = '0;
    tick();
    tick();
    chk("rst_wb_valid", {63'd0, o_wb_valid}, 64'd0);
    chk("rst_wb_rd", {59'd0, o_wb_rd}, 64'd0);
    chk("rst_wb_data", {32'd0, o_wb_data}, 64'd0);
    chk("rst_busy", {32'd0, o_busy}, 64'd0);
    chk("rst_inflight", {60'd0, o_inflight}, 64'd0);
    rst = 1'b0;
    tick();

    // Single DIV: busy[5] for exactly DEPTH cycles.
    issue(DIV_OP_DIV, 5'd5, 32'd100, 32'd7, 32'd14, 8, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      chk("t1_busy5", {63'd0, o_busy[5]}, 64'd1);
      chk("t1_inflight", {60'd0, o_inflight}, 64'd1);
      tick();
    end
    chk("t1_busy5_clear", {63'd0, o_busy[5]}, 64'd0);
    chk("t1_inflight_clear", {60'd0, o_inflight}, 64'd0);
    drain();

    // Back-to-back mixed ops retire in order on consecutive cycles.
    issue(DIV_OP_DIV,  5'd4, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 8, 1'b1);
    issue(DIV_OP_REM,  5'd1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 8, 1'b1);
    issue(DIV_OP_DIVU, 5'd2, 32'hFFFF_FFFE, 32'd3, 32'h5555_5554, 8, 1'b1);
    issue(DIV_OP_REMU, 5'd3, 32'd10, 32'd3, 32'd1, 8, 1'b1);
    chk("b2b_busy", {32'd0, o_busy}, 64'h1E);
    chk("b2b_inflight", {60'd0, o_inflight}, 64'd4);
    drain();

    // Zero divisor, signed overflow, and an rd=0 op that never writes back.
    issue(DIV_OP_DIV,  5'd6,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 8, 1'b1);
    issue(DIV_OP_REM,  5'd7,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 8, 1'b1);
    issue(DIV_OP_DIV,  5'd8,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 8, 1'b1);
    issue(DIV_OP_REM,  5'd9,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 8, 1'b1);
    issue(DIV_OP_REMU, 5'd0,  32'd7, 32'd3, 32'd1, 8, 1'b1);
    issue(DIV_OP_DIVU, 5'd10, 32'd5, 32'd0, 32'hFFFF_FFFF, 8, 1'b1);
    issue(DIV_OP_REMU, 5'd11, 32'd5, 32'd0, 32'd5, 8, 1'b1);
    chk("dz_busy", {32'd0, o_busy}, 64'hFC0);
    chk("dz_inflight", {60'd0, o_inflight}, 64'd7);
    drain();

    // Three-cycle stall at the pipeline midpoint.
    issue(DIV_OP_DIV, 5'd12, 32'd20, 32'd4, 32'd5, 11, 1'b1);
    tick(); tick(); tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_wb_valid", {63'd0, o_wb_valid}, 64'd0);
      chk("stall_inflight", {60'd0, o_inflight}, 64'd1);
      tick();
    end
    stall = 1'b0;
    drain();

    // Flush kills in-flight ops and the op issued alongside it.
    issue(DIV_OP_DIV, 5'd13, 32'd50, 32'd5, 32'd10, 8, 1'b0);
    issue(DIV_OP_DIV, 5'd14, 32'd60, 32'd5, 32'd12, 8, 1'b0);
    issue(DIV_OP_DIV, 5'd15, 32'd70, 32'd5, 32'd14, 8, 1'b0);
    chk("pre_flush_inflight", {60'd0, o_inflight}, 64'd3);
    i_flush = 1'b1;
    issue(DIV_OP_DIV, 5'd16, 32'd80, 32'd5, 32'd16, 8, 1'b0);
    i_flush = 1'b0;
    chk("flush_busy", {32'd0, o_busy}, 64'd0);
    chk("flush_inflight", {60'd0, o_inflight}, 64'd0);
    issue(DIV_OP_DIVU, 5'd17, 32'd9, 32'd2, 32'd4, 8, 1'b1);
    drain();

    // Reset with six ops in flight.
    for (int i = 0; i < 6; i++) begin
      issue(DIV_OP_DIVU, 5'(20 + i), 32'd100, 32'(i + 1), 32'd0, 8, 1'b0);
    end
    chk("pre_rst_inflight", {60'd0, o_inflight}, 64'd6);
    rst = 1'b1;
    tick();
    chk("mid_rst_wb_valid", {63'd0, o_wb_valid}, 64'd0);
    chk("mid_rst_wb_rd", {59'd0, o_wb_rd}, 64'd0);
    chk("mid_rst_wb_data", {32'd0, o_wb_data}, 64'd0);
    chk("mid_rst_busy", {32'd0, o_busy}, 64'd0);
    chk("mid_rst_inflight", {60'd0, o_inflight}, 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    chk("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_issue_tracker.md
# div_issue_tracker

Control wrapper around the 8-stage pipelined integer divider in the execute stage. Accepts RV32M DIV/DIVU/REM/REMU ops from issue and drives the divider operands. Carries a side pipeline of valid, destination register, op and dividend in lock-step with the divider stages. At the divider output it selects quotient or remainder, applies the RISC-V divide-by-zero fix-up, and presents a writeback beat plus a busy scoreboard for hazard stalling.

## Interface
- DEPTH, 8, divider stage count; must equal the divider's pipeline depth
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  global pipeline stall; shared with the divider's stall
- i_flush  in  1  kill every in-flight op
- i_valid  in  1  issue request
- i_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- i_rd  in  5  destination register
- i_rs1  in  32  dividend
- i_rs2  in  32  divisor
- o_div_is_signed  out  1  to divider is_signed
- o_div_dividend  out  32  to divider i_dividend
- o_div_divisor  out  32  to divider i_divisor
- i_div_quotient  in  32  from divider o_quotient
- i_div_remainder  in  32  from divider o_remainder
- o_wb_valid  out  1  writeback beat valid
- o_wb_rd  out  5  writeback register
- o_wb_data  out  32  writeback value
- o_busy  out  32  bit r set while an op targeting xr is in flight; bit 0 always 0
- o_inflight  out  4  count of valid tracker stages, 0..DEPTH

## Operation
**Side pipeline**
- DEPTH entries. Each entry holds: vld, rd[4:0], op[1:0], dz (divisor==0), dividend[31:0].
- Entry 0 loads from issue. Entry k loads from entry k-1.

**Issue**
- Issue is accepted when i_valid=1, stall=0 and i_flush=0.
- While i_valid=1, operands are driven combinationally: o_div_is_signed = ~i_op[0].
- While i_valid=0, o_div_is_signed, o_div_dividend and o_div_divisor are driven 0, so a bubble enters the divider.
- If i_valid=1 and stall=1, the op is not accepted. Upstream holds it.

**Advance**
- On each edge with stall=0, all entries shift.
- The entry 0 valid bit is set only on an accepted issue.

**Flush**
- On an edge with i_flush=1, every vld clears, regardless of stall.
- The divider datapath is not flushed. Its bubbles are ignored because vld=0.

**Result select**, from entry DEPTH-1:
- REM/REMU (op[1]=1): remainder. DIV/DIVU: quotient.
- Divide-by-zero (dz=1), all ops: quotient forced to 0xFFFFFFFF; remainder forced to the stored dividend. This corrects the divider's signed result for negative dividends.
- Signed overflow (0x80000000 / 0xFFFFFFFF) needs no fix-up: the divider already yields quotient 0x80000000 and remainder 0.

**Writeback**
- o_wb_valid = vld[DEPTH-1] & (rd != 0) & ~stall.
- o_wb_rd and o_wb_data are always driven from the last entry.

**Busy scoreboard**
- o_busy bit r = OR over entries of (vld & rd==r), for r != 0.
- o_inflight = popcount of vld.
- Both outputs are combinational from the registers.

## Timing
- Reset:
  - All vld=0; rd, op, dz and dividend in every entry = 0.
  - Resulting outputs: o_wb_valid=0, o_wb_rd=0, o_wb_data=0, o_busy=0, o_inflight=0.
- Latency:
  - An op accepted at edge E0 appears on the wb outputs after DEPTH non-stalled edges (E0 included).
  - With no stalls, a beat issued in cycle T writes back in cycle T+DEPTH.
- Throughput: one op per non-stalled cycle.
- Stall: all entries hold and o_wb_valid=0. The wb beat re-presents when stall drops, and is counted once.
- Priority: rst > i_flush > stall > issue.
- Same-rd issue while busy is legal. o_busy stays set until the last matching entry retires.
- An entry retiring and a new issue in the same edge with the same rd: o_busy stays 1.
- Back-to-back, duplicate and rd=0 ops need no special-case logic.

## Structure
- Shared package div_pkg:
  - op encodings DIV_OP_DIV/DIVU/REM/REMU
  - DIV_DEPTH=8
  - DIV_ZERO_QUOT=32'hFFFFFFFF
  - packed struct div_tag_t {vld, rd, op, dz, dividend}
- Sub-module div_fixup: combinational result select and zero-divisor override.
- Top level: registers, scoreboard reduction and popcount.
- Top level instantiates the divider externally. The bench instantiates both.

## Test plan
- DIV 100/7, rd=5, no stall -> cycle T+8: wb_valid=1, rd=5, data=14; o_busy[5]=1 for cycles T+1..T+8.
- REM -7/2 -> 0xFFFFFFFF (-1); DIVU 0xFFFFFFFE/3 -> 0x55555554; REMU 10/3 -> 1. Issue all back-to-back; the results retire in four consecutive cycles, in order.
- DIV -5/0 -> 0xFFFFFFFF; REM -5/0 -> 0xFFFFFFFB; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 with REM 0.
- Issue DIV 20/4, then stall for 3 cycles at the pipeline midpoint -> result 5 arrives at T+11. wb_valid stays 0 while stalled; there is exactly one wb beat.
- Issue 4 ops, then i_flush on cycle T+3 -> no wb beats follow; o_busy=0 and o_inflight=0 after the flush edge. An op issued after the flush retires normally.
- rst asserted mid-stream with 6 ops in flight -> all outputs 0 next cycle; no stale wb beat appears after rst releases.
